// File: rtl/sipo_rx_if.sv
// Handshake/data bundle between the serial-link receiver and its consumer.
// master drives the serial stream and acknowledge; slave is the receiver.
interface sipo_rx_if #(
  parameter int W = 4
);
  localparam int KW = $clog2(W);

  logic          en;
  logic          s;
  logic          clr;
  logic          ack;
  logic [W-1:0]  o;
  logic          v;
  logic          ovf;
  logic          busy;
  logic [KW-1:0] k;

  modport master (
    output en, s, clr, ack,
    input  o, v, ovf, busy, k
  );

  modport slave (
    input  en, s, clr, ack,
    output o, v, ovf, busy, k
  );
endinterface

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles W-bit words from a bit stream,
// holds each finished word with valid/ack, and flags words dropped while full.
module sipo_rx #(
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     c_i,
  input  logic     r_ni,
  sipo_rx_if.slave bus
);
  localparam int KW = $clog2(W);
  localparam logic [KW-1:0] KLast = KW'(W - 1);

  logic [W-1:0]  sh_q, sh_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  o_q, o_d;
  logic          v_q, v_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  shifted;
  logic          complete;

  assign shifted  = MSB_FIRST ? {sh_q[W-2:0], bus.s} : {bus.s, sh_q[W-1:1]};
  assign complete = bus.en && (k_q == KLast);

  // clr outranks everything, including a word completing on the same edge.
  always_comb begin
    sh_d  = sh_q;
    k_d   = k_q;
    o_d   = o_q;
    v_d   = v_q;
    ovf_d = ovf_q;
    if (bus.clr) begin
      sh_d  = '0;
      k_d   = '0;
      v_d   = 1'b0;
      ovf_d = 1'b0;
    end else begin
      if (bus.en) begin
        sh_d = shifted;
        k_d  = complete ? '0 : k_q + KW'(1);
      end
      if (complete) begin
        if (!v_q || bus.ack) begin
          o_d = shifted;
          v_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (bus.ack && v_q) begin
        v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge c_i or negedge r_ni) begin
    if (!r_ni) begin
      sh_q  <= '0;
      k_q   <= '0;
      o_q   <= '0;
      v_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      k_q   <= k_d;
      o_q   <= o_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.o    = o_q;
  assign bus.v    = v_q;
  assign bus.ovf  = ovf_q;
  assign bus.k    = k_q;
  assign bus.busy = (k_q != '0);
endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in parallel-out receiver that reassembles W-bit words from the single-bit stream produced by the team's parallel-in serial-out shifter. It sits at the far end of the serial link. It counts bits under a shift enable, presents each completed word on a held parallel output with a valid/acknowledge handshake, and flags words lost to an unacknowledged output. Bit order is selectable to match the transmitter, which sends MSB first.

## Interface
- `W`, default 4: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `o[W-1]`; 0 means the first received bit lands in `o[0]`.
- `c`  in  1: clock; all state changes on the rising edge.
- `r`  in  1: reset, asynchronous, active-low (`r`=0 resets).
- `en`  in  1: shift enable; when 1, `s` is sampled on this edge as the next bit.
- `s`  in  1: serial data in.
- `clr`  in  1: synchronous frame restart.
- `ack`  in  1: consumer acknowledge of the current word.
- `o`  out  W: last completed word; held until the next accepted word.
- `v`  out  1: word valid; stays high until acknowledged.
- `ovf`  out  1: sticky overflow flag.
- `busy`  out  1: a frame is partially received (`k` ≠ 0).
- `k`  out  clog2(W): number of bits received in the current frame.

## Operation
- Internal shift register `sh[W-1:0]` and bit counter `k` (0..W-1).
- Reset (`r`=0, asynchronous, any time):
  - `sh`, `k`, `o`, `v`, and `ovf` are cleared to 0.
  - `busy` is 0.
  - A partial frame is discarded.
- Priority on each edge: `clr` > `en`. `ack` is evaluated independently.
- `clr`=1:
  - `k`←0, `sh`←0, `v`←0, `ovf`←0.
  - `o` holds its value.
  - `en` is ignored that cycle.
- `en`=1, `clr`=0:
  - MSB_FIRST=1: `sh`←{`sh[W-2:0]`, `s`}.
  - MSB_FIRST=0: `sh`←{`s`, `sh[W-1:1]`}.
  - If `k`<W-1: `k`←`k`+1.
- Word completion is `en`=1 with `k`=W-1:
  - `k` wraps to 0.
  - The assembled word is the shifted value including the current `s`.
  - Accepted when `v`=0, or when `v`=1 and `ack`=1 on the same edge: `o`←word and `v`←1.
  - Dropped when `v`=1 and `ack`=0: `o` is unchanged, `v` stays 1, and `ovf`←1.
- `ack`=1 with `v`=1 and no acceptance on that edge: `v`←0.
- `ack` while `v`=0 is ignored.
- `en`=0: `sh` and `k` hold. Gaps between bits are unlimited and legal.
- `ovf` clears only on `clr` or reset.

## Timing
- Latency: the last bit is sampled on edge N. `o` and `v` are valid after edge N, which is the same edge with no extra pipeline stage.
- With continuous `en`, a word completes every W cycles. The consumer must assert `ack` within W cycles of `v` rising to avoid overflow.
- `busy` and `k` are registered values. `busy` is 1 from the edge after the first bit until the edge that completes the word.
- `o`, `v`, and `ovf` are registered outputs with no combinational path from the inputs.
- `clr` and completion on the same edge: `clr` wins, the word is lost, and `ovf` is not set.
- Reset is asserted asynchronously. Deassertion is synchronized externally. The first sampled bit is on the first edge with `r`=1 and `en`=1.

## Test plan
- Reset: with `r`=0, all outputs are 0. Release reset, assert `en` for 4 cycles with `s`=1,1,0,1 (W=4, MSB_FIRST=1). Required: `o`=4'b1101 and `v`=1 after the 4th edge; `k`=1,2,3,0 after the successive edges; `busy` is 1 for 3 cycles.
- Repeat the `s`=1,1,0,1 stimulus with MSB_FIRST=0. Required: `o`=4'b1011.
- Back-to-back words 1101 then 0110 with continuous `en`, and `ack` pulsed on the edge that completes the second word. Required: `o`=0110, `v` stays 1, `ovf`=0.
- Overflow: receive 1101, do not `ack`, then receive 0011. Required: `o` stays 1101, `v`=1, `ovf`=1. Then `ack`: `v`→0 and `ovf` stays 1. Then `clr`: `ovf`→0.
- Mid-frame `clr` after 2 bits, then the full word 1001 with 3 idle cycles (`en`=0) inserted between bits. Required: `o`=1001 and no spurious `v` before the 4th accepted bit.
- Asynchronous reset asserted between clock edges after 3 bits while `v`=1. Required: `k`, `v`, `o`, and `ovf` go to 0 immediately without a clock edge; the next word assembles correctly from bit 0.
